// File: rtl/dct_pkg.sv
// Shared constants and output rounding for the team's 8-point forward and inverse DCT.
// Cosines are Q13; results are rounded at bit 13 and shifted by 14.
package dct_pkg;

  localparam int DCT_IN_W  = 11;
  localparam int DCT_OUT_W = 10;
  localparam int DCT_ACC_W = 27;

  localparam int COEF_W    = 13;
  localparam int ROUND_BIT = 13;
  localparam int SHIFT     = 14;

  // cos(k*pi/16) * 8192, rounded
  localparam logic [COEF_W-1:0] A = 13'd5793;
  localparam logic [COEF_W-1:0] B = 13'd7568;
  localparam logic [COEF_W-1:0] C = 13'd3135;
  localparam logic [COEF_W-1:0] D = 13'd8035;
  localparam logic [COEF_W-1:0] E = 13'd6811;
  localparam logic [COEF_W-1:0] F = 13'd4551;
  localparam logic [COEF_W-1:0] G = 13'd1598;

  // One extra bit so the round-up increment can never wrap.
  localparam int RND_W = DCT_ACC_W - SHIFT + 1;

  // Round half up at ROUND_BIT, then clamp to the signed output range.
  // Returns {clip, sample}.
  function automatic logic [DCT_OUT_W:0] sat_round(input logic signed [DCT_ACC_W-1:0] s);
    logic signed [RND_W-1:0] r;
    logic signed [RND_W-1:0] r_max;
    logic signed [RND_W-1:0] r_min;
    r_max = {{(RND_W-DCT_OUT_W+1){1'b0}}, {(DCT_OUT_W-1){1'b1}}};
    r_min = {{(RND_W-DCT_OUT_W+1){1'b1}}, {(DCT_OUT_W-1){1'b0}}};
    r = $signed({s[DCT_ACC_W-1], s[DCT_ACC_W-1:SHIFT]})
      + $signed({{(RND_W-1){1'b0}}, s[ROUND_BIT]});
    if (r > r_max) begin
      return {1'b1, r_max[DCT_OUT_W-1:0]};
    end else if (r < r_min) begin
      return {1'b1, r_min[DCT_OUT_W-1:0]};
    end
    return {1'b0, r[DCT_OUT_W-1:0]};
  endfunction

endpackage

// File: rtl/idct_1d_if.sv
// Coefficient-in / sample-out streaming bus of the 1-D IDCT (valid/ready both sides).
interface idct_1d_if
  import dct_pkg::*;
#(
  parameter int IN_W  = DCT_IN_W,
  parameter int OUT_W = DCT_OUT_W
);

  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  y [8];
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] x [8];
  logic                    sat;

  modport master (
    output in_valid, y, out_ready,
    input  in_ready, out_valid, x, sat
  );

  modport slave (
    input  in_valid, y, out_ready,
    output in_ready, out_valid, x, sat
  );

endinterface

// File: rtl/idct_round_sat.sv
// One output lane: round an accumulator sum to a sample and flag clipping.
module idct_round_sat
  import dct_pkg::*;
#(
  parameter int ACC_W = DCT_ACC_W,
  parameter int OUT_W = DCT_OUT_W
) (
  input  logic signed [ACC_W-1:0] s_i,
  output logic signed [OUT_W-1:0] x_o,
  output logic                    clip_o
);

  logic [DCT_OUT_W:0] rs;

  assign rs     = sat_round(s_i);
  assign clip_o = rs[DCT_OUT_W];
  assign x_o    = rs[DCT_OUT_W-1:0];

endmodule

// File: rtl/idct_1d.sv
// 8-point 1-D inverse DCT, five-stage pipeline with valid/ready and a single global stall.
// Even/odd decomposition: constant products, pairwise sums, final sums, then butterfly + round.
module idct_1d
  import dct_pkg::*;
#(
  parameter int IN_W  = DCT_IN_W,
  parameter int OUT_W = DCT_OUT_W,
  parameter int ACC_W = DCT_ACC_W
) (
  input logic      clk,
  input logic      rst,
  idct_1d_if.slave bus
);

  localparam int PROD_W = IN_W + COEF_W;

  function automatic logic signed [PROD_W-1:0] mulk(input logic signed [IN_W-1:0] y,
                                                    input logic [COEF_W-1:0]     k);
    logic signed [PROD_W:0] ye;
    logic signed [PROD_W:0] ke;
    logic signed [PROD_W:0] p;
    ye = {{(PROD_W+1-IN_W){y[IN_W-1]}}, y};
    ke = {{(PROD_W+1-COEF_W){1'b0}}, k};
    p  = ye * ke;
    return p[PROD_W-1:0];
  endfunction

  function automatic logic signed [ACC_W-1:0] sx(input logic signed [PROD_W-1:0] p);
    return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction

  logic en;
  logic out_valid_q;

  logic signed [IN_W-1:0]   y_p0_q [8];
  logic                     vld_p0_q;
  // even_p1: Ay0, Ay4, By2, Cy2, By6, Cy6; odd_p1[coef D..G][input y1,y3,y5,y7]
  logic signed [PROD_W-1:0] even_p1_d [6];
  logic signed [PROD_W-1:0] even_p1_q [6];
  logic signed [PROD_W-1:0] odd_p1_d  [4][4];
  logic signed [PROD_W-1:0] odd_p1_q  [4][4];
  logic                     vld_p1_q;
  logic signed [ACC_W-1:0]  even_p2_d [4];
  logic signed [ACC_W-1:0]  even_p2_q [4];
  logic signed [ACC_W-1:0]  oa_p2_d   [4];
  logic signed [ACC_W-1:0]  oa_p2_q   [4];
  logic signed [ACC_W-1:0]  ob_p2_d   [4];
  logic signed [ACC_W-1:0]  ob_p2_q   [4];
  logic                     vld_p2_q;
  logic signed [ACC_W-1:0]  e_p3_d    [4];
  logic signed [ACC_W-1:0]  e_p3_q    [4];
  logic signed [ACC_W-1:0]  o_p3_d    [4];
  logic signed [ACC_W-1:0]  o_p3_q    [4];
  logic                     vld_p3_q;
  logic signed [ACC_W-1:0]  s_d       [8];
  logic signed [OUT_W-1:0]  x_d       [8];
  logic signed [OUT_W-1:0]  x_q       [8];
  logic [7:0]               clip_d;
  logic                     sat_d;
  logic                     sat_q;

  // The whole pipe advances only when the output slot is free or being drained.
  assign bus.in_ready = !(out_valid_q && !bus.out_ready);
  assign en           = bus.in_ready;

  // ---- S1: constant products ----
  always_comb begin
    even_p1_d[0] = mulk(y_p0_q[0], A);
    even_p1_d[1] = mulk(y_p0_q[4], A);
    even_p1_d[2] = mulk(y_p0_q[2], B);
    even_p1_d[3] = mulk(y_p0_q[2], C);
    even_p1_d[4] = mulk(y_p0_q[6], B);
    even_p1_d[5] = mulk(y_p0_q[6], C);
    for (int k = 0; k < 4; k++) begin
      odd_p1_d[0][k] = mulk(y_p0_q[2*k+1], D);
      odd_p1_d[1][k] = mulk(y_p0_q[2*k+1], E);
      odd_p1_d[2][k] = mulk(y_p0_q[2*k+1], F);
      odd_p1_d[3][k] = mulk(y_p0_q[2*k+1], G);
    end
  end

  // ---- S2a: pairwise sums ----
  always_comb begin
    even_p2_d[0] = sx(even_p1_q[0]) + sx(even_p1_q[1]);
    even_p2_d[1] = sx(even_p1_q[0]) - sx(even_p1_q[1]);
    even_p2_d[2] = sx(even_p1_q[2]) + sx(even_p1_q[5]);
    even_p2_d[3] = sx(even_p1_q[3]) - sx(even_p1_q[4]);
    oa_p2_d[0]   = sx(odd_p1_q[0][0]) + sx(odd_p1_q[1][1]);
    ob_p2_d[0]   = sx(odd_p1_q[2][2]) + sx(odd_p1_q[3][3]);
    oa_p2_d[1]   = sx(odd_p1_q[1][0]) - sx(odd_p1_q[3][1]);
    ob_p2_d[1]   = sx(odd_p1_q[0][2]) + sx(odd_p1_q[2][3]);
    oa_p2_d[2]   = sx(odd_p1_q[2][0]) - sx(odd_p1_q[0][1]);
    ob_p2_d[2]   = sx(odd_p1_q[3][2]) + sx(odd_p1_q[1][3]);
    oa_p2_d[3]   = sx(odd_p1_q[3][0]) - sx(odd_p1_q[2][1]);
    ob_p2_d[3]   = sx(odd_p1_q[1][2]) - sx(odd_p1_q[0][3]);
  end

  // ---- S3: final even/odd sums (o1's second pair enters negated) ----
  always_comb begin
    e_p3_d[0] = even_p2_q[0] + even_p2_q[2];
    e_p3_d[1] = even_p2_q[1] + even_p2_q[3];
    e_p3_d[2] = even_p2_q[1] - even_p2_q[3];
    e_p3_d[3] = even_p2_q[0] - even_p2_q[2];
    o_p3_d[0] = oa_p2_q[0] + ob_p2_q[0];
    o_p3_d[1] = oa_p2_q[1] - ob_p2_q[1];
    o_p3_d[2] = oa_p2_q[2] + ob_p2_q[2];
    o_p3_d[3] = oa_p2_q[3] + ob_p2_q[3];
  end

  // ---- S4: butterfly, round, clamp ----
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      s_d[n]   = e_p3_q[n] + o_p3_q[n];
      s_d[7-n] = e_p3_q[n] - o_p3_q[n];
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_lane
    idct_round_sat #(
      .ACC_W (ACC_W),
      .OUT_W (OUT_W)
    ) u_round_sat (
      .s_i    (s_d[g]),
      .x_o    (x_d[g]),
      .clip_o (clip_d[g])
    );
  end

  assign sat_d = |clip_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0_q    <= 1'b0;
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      vld_p3_q    <= 1'b0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        y_p0_q[i] <= '0;
        x_q[i]    <= '0;
      end
      for (int i = 0; i < 6; i++) even_p1_q[i] <= '0;
      for (int i = 0; i < 4; i++) begin
        for (int k = 0; k < 4; k++) odd_p1_q[i][k] <= '0;
        even_p2_q[i] <= '0;
        oa_p2_q[i]   <= '0;
        ob_p2_q[i]   <= '0;
        e_p3_q[i]    <= '0;
        o_p3_q[i]    <= '0;
      end
    end else if (en) begin
      vld_p0_q    <= bus.in_valid;
      vld_p1_q    <= vld_p0_q;
      vld_p2_q    <= vld_p1_q;
      vld_p3_q    <= vld_p2_q;
      out_valid_q <= vld_p3_q;
      sat_q       <= sat_d;
      for (int i = 0; i < 8; i++) begin
        y_p0_q[i] <= bus.y[i];
        x_q[i]    <= x_d[i];
      end
      even_p1_q <= even_p1_d;
      odd_p1_q  <= odd_p1_d;
      even_p2_q <= even_p2_d;
      oa_p2_q   <= oa_p2_d;
      ob_p2_q   <= ob_p2_d;
      e_p3_q    <= e_p3_d;
      o_p3_q    <= o_p3_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.sat       = sat_q;

  always_comb begin
    for (int i = 0; i < 8; i++) bus.x[i] = x_q[i];
  end

endmodule
